pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 112 +++++++++++
 tb/tb_pipe_stage_reg.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid buffer,
// bubble insertion on flush and a saturating back-pressure counter.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 11,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              push;
  logic              pop;

  // Skid mode breaks the out_ready -> in_ready path; single-register mode keeps it.
  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign occupancy = state_q;
  assign stall_cnt = stall_cnt_q;
  // Payload registers are not reset; gating by valid gives NOP bubbles.
  assign out_ctrl  = out_valid ? head_ctrl_q : '0;
  assign out_data  = out_valid ? head_data_q : '0;

  always_comb begin
    state_d     = state_q;
    head_ctrl_d = head_ctrl_q;
    head_data_d = head_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d     = BUSY;
          head_ctrl_d = in_ctrl;
          head_data_d = in_data;
        end
      end
      BUSY: begin
        if (push && pop) begin
          head_ctrl_d = in_ctrl;
          head_data_d = in_data;
        end else if (push && (SKID != 0)) begin
          state_d     = FULL;
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d     = BUSY;
          head_ctrl_d = skid_ctrl_q;
          head_data_d = skid_data_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
    if (out_valid && !out_ready && !flush && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    head_ctrl_q <= head_ctrl_d;
    head_data_q <= head_data_d;
    skid_ctrl_q <= skid_ctrl_d;
    skid_data_q <= skid_data_d;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a skid instance (CNT_W=4) tracked by a FIFO
// model every cycle, plus a single-register instance exercised directly.
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 11;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst, flush;
  logic              in_valid, in_ready, out_valid, out_ready;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  logic              b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [CTRL_W-1:0] b_in_ctrl, b_out_ctrl;
  logic [DATA_W-1:0] b_in_data, b_out_data;
  logic [1:0]        b_occupancy;
  logic [15:0]       b_stall_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  bit mon_en = 1'b0;

  logic [CTRL_W+DATA_W-1:0] sb_q[$];
  int                       stall_m = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl),
    .out_data(b_out_data), .occupancy(b_occupancy), .stall_cnt(b_stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  // Model state at the negedge reflects the last posedge; then predict the next one.
  always @(negedge clk) begin
    if (mon_en) begin
      check("occupancy", occupancy, sb_q.size());
      check("out_valid", out_valid, sb_q.size() != 0);
      check("in_ready", in_ready, sb_q.size() != 2);
      check("stall_cnt", stall_cnt, stall_m);
      if (sb_q.size() != 0) check("head", {out_ctrl, out_data}, sb_q[0]);
      else                  check("bubble", {out_ctrl, out_data}, '0);
      if (rst) begin
        sb_q.delete();
        stall_m = 0;
      end else begin
        if ((sb_q.size() != 0) && !out_ready && !flush && (stall_m != 15)) stall_m++;
        if (flush) begin
          sb_q.delete();
        end else begin
          if (out_valid && out_ready && (sb_q.size() != 0)) void'(sb_q.pop_front());
          if (in_valid && in_ready) sb_q.push_back({in_ctrl, in_data});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0);
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_ctrl = '0; b_in_data = '0; b_out_ready = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_occ", occupancy, 2'd0);

    // streaming
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 11'(i + 1), 32'h100 + 32'(4 * i));
      tick();
      check("stream_data", out_data, 32'h100 + 32'(4 * i));
      check("stream_occ", occupancy, 2'd1);
    end
    drive(1'b0, '0, '0);
    tick();
    check("stream_empty", out_valid, 1'b0);
    check("stream_stall", stall_cnt, 4'd0);

    // back-pressure
    out_ready = 1'b0;
    drive(1'b1, 11'h0A, 32'hA); tick();
    drive(1'b1, 11'h0B, 32'hB); tick();
    check("bp_occ", occupancy, 2'd2);
    check("bp_in_ready", in_ready, 1'b0);
    drive(1'b1, 11'h0C, 32'hC);
    repeat (4) tick();
    check("bp_stall", stall_cnt, 4'd5);
    check("bp_held_head", out_data, 32'hA);
    out_ready = 1'b1;
    tick();
    check("bp_second", out_data, 32'hB);
    tick();
    check("bp_third", out_data, 32'hC);
    drive(1'b0, '0, '0);
    tick();
    check("bp_drained", occupancy, 2'd0);

    // flush while FULL
    out_ready = 1'b0;
    drive(1'b1, 11'h7FF, 32'h11); tick();
    drive(1'b1, 11'h7FF, 32'h22); tick();
    check("fl_full", occupancy, 2'd2);
    flush = 1'b1;
    drive(1'b1, 11'h7FF, 32'h33);
    tick();
    flush = 1'b0;
    drive(1'b0, '0, '0);
    check("fl_valid", out_valid, 1'b0);
    check("fl_ctrl", out_ctrl, 11'h000);
    check("fl_occ", occupancy, 2'd0);
    check("fl_stall", stall_cnt, 4'd6);
    check("fl_in_ready", in_ready, 1'b1);
    tick();
    check("fl_dropped", occupancy, 2'd0);

    // rst and flush together while FULL with stall_cnt=9
    drive(1'b1, 11'h5, 32'h55); tick();
    drive(1'b1, 11'h6, 32'h66); tick();
    drive(1'b0, '0, '0);
    repeat (2) tick();
    check("rf_pre_stall", stall_cnt, 4'd9);
    rst = 1'b1; flush = 1'b1;
    drive(1'b1, 11'h7, 32'h77);
    tick();
    rst = 1'b0; flush = 1'b0;
    drive(1'b0, '0, '0);
    check("rf_stall", stall_cnt, 4'd0);
    check("rf_occ", occupancy, 2'd0);
    check("rf_out", {out_valid, out_ctrl, out_data}, '0);
    check("rf_in_ready", in_ready, 1'b1);

    // saturation
    drive(1'b1, 11'h1, 32'hBEEF); tick();
    drive(1'b0, '0, '0);
    repeat (20) tick();
    check("sat_15", stall_cnt, 4'd15);
    repeat (3) tick();
    check("sat_hold", stall_cnt, 4'd15);
    out_ready = 1'b1;
    tick();
    check("sat_drain", out_valid, 1'b0);

    // single-register replace
    b_in_valid = 1'b1; b_in_data = 32'h1; b_in_ctrl = 11'h1;
    tick();
    check("s0_head", b_out_data, 32'h1);
    check("s0_occ1", b_occupancy, 2'd1);
    b_in_data = 32'h2; b_in_ctrl = 11'h2; b_out_ready = 1'b1;
    #1;
    check("s0_ready_comb", b_in_ready, 1'b1);
    tick();
    check("s0_replace", b_out_data, 32'h2);
    check("s0_occ_replace", b_occupancy, 2'd1);
    b_out_ready = 1'b0;
    #1;
    check("s0_not_ready", b_in_ready, 1'b0);
    tick();
    check("s0_hold", {b_out_data, b_occupancy}, {32'h2, 2'd1});
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    tick();
    check("s0_empty", {b_out_valid, b_out_ctrl, b_out_data, b_occupancy}, '0);
    check("s0_stall", b_stall_cnt, 16'd1);

    tick();
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
